// File: rtl/lpc_arb_pkg.sv
// lpc_arb_pkg: shared widths, timeout data and FSM states for the LPC host arbiter.
package lpc_arb_pkg;
    localparam int LPC_ADDR_W = 16;
    localparam int LPC_DATA_W = 8;
    localparam logic [LPC_DATA_W-1:0] TIMEOUT_DATA = 8'hFF;
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE, DRAIN} arbState;
endpackage

// File: rtl/lpc_arb_pick.sv
// lpc_arb_pick: winner select scanning requests upward from ptr_i (ptr_i = 0 gives fixed priority).
module lpc_arb_pick #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [1:0]         ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [1:0]         idx_o,
    output logic               any_o
);
    logic found;
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++)
            for (int i = 0; i < NUM_REQ; i++)
                if (!found && req_i[i] && i == (int'(ptr_i) + k) % NUM_REQ) begin
                    found    = 1'b1;
                    gnt_o[i] = 1'b1;
                    idx_o    = 2'(i);
                end
        any_o = found;
    end
endmodule

// File: rtl/lpc_host_arbiter.sv
// lpc_host_arbiter: shares one LPC host engine among NUM_REQ requesters with a timeout abort.
// Define LPC_ARB_ROUND_ROBIN_EN for round-robin; otherwise fixed priority, index 0 highest.
module lpc_host_arbiter
    import lpc_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            reqValid,
    input  logic [NUM_REQ-1:0]            reqIsWrite,
    input  logic [LPC_ADDR_W*NUM_REQ-1:0] reqAddr,
    input  logic [LPC_DATA_W*NUM_REQ-1:0] reqWData,
    output logic [NUM_REQ-1:0]            reqAccept,
    output logic [NUM_REQ-1:0]            rspValid,
    output logic [LPC_DATA_W-1:0]         rspData,
    output logic                          rspTimeout,
    output logic [LPC_ADDR_W-1:0]         hostAddr,
    output logic [LPC_DATA_W-1:0]         hostInData,
    output logic                          hostIsWrite,
    output logic                          hostStart,
    input  logic                          hostIsReady,
    input  logic                          hostGotResponse,
    input  logic [LPC_DATA_W-1:0]         hostOutData,
    output logic [1:0]                    grantIdx,
    output logic                          busy
);
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    arbState               state_q, state_d;
    logic [NUM_REQ-1:0]    own_q, own_d, rsp_valid_q, rsp_valid_d, pick_gnt;
    logic [1:0]            grant_q, grant_d, pick_idx, rr_ptr;
    logic [LPC_ADDR_W-1:0] addr_q, addr_d;
    logic [LPC_DATA_W-1:0] wdata_q, wdata_d, rsp_data_q, rsp_data_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  wr_q, wr_d, rsp_to_q, rsp_to_d, pick_any, grant, done;
    assign grant = state_q == IDLE && pick_any && hostIsReady;
`ifdef LPC_ARB_ROUND_ROBIN_EN
    logic [1:0] rr_q, rr_d;
    assign rr_d   = grant ? 2'((int'(pick_idx) + 1) % NUM_REQ) : rr_q;
    assign rr_ptr = rr_q;
    always_ff @(posedge clk or posedge reset)
        if (reset) rr_q <= '0;
        else rr_q <= rr_d;
`else
    assign rr_ptr = '0;
`endif
    lpc_arb_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req_i(reqValid),
        .ptr_i(rr_ptr),
        .gnt_o(pick_gnt),
        .idx_o(pick_idx),
        .any_o(pick_any)
    );
    // Counter reads n in the n-th cycle after hostStart, so the abort response lands at TIMEOUT_CYCLES.
    always_comb begin
        state_d     = state_q;
        own_d       = own_q;
        grant_d     = grant_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wr_d        = wr_q;
        cnt_d       = cnt_q;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        rsp_to_d    = 1'b0;
        done        = (hostGotResponse && !wr_q) || (state_q == WAIT_DONE && wr_q && hostIsReady);
        case (state_q)
            IDLE: if (grant) begin
                state_d = ISSUE;
                own_d   = pick_gnt;
                grant_d = pick_idx;
                wr_d    = |(reqIsWrite & pick_gnt);
                for (int i = 0; i < NUM_REQ; i++)
                    if (pick_gnt[i]) begin
                        addr_d  = reqAddr[i*LPC_ADDR_W +: LPC_ADDR_W];
                        wdata_d = reqWData[i*LPC_DATA_W +: LPC_DATA_W];
                    end
            end
            ISSUE: begin
                state_d = WAIT_ACK;
                cnt_d   = CW'(1);
            end
            WAIT_ACK, WAIT_DONE: if (done) begin
                state_d     = IDLE;
                rsp_valid_d = own_q;
                rsp_data_d  = wr_q ? rsp_data_q : hostOutData;
            end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                state_d     = DRAIN;
                rsp_valid_d = own_q;
                rsp_to_d    = 1'b1;
                rsp_data_d  = TIMEOUT_DATA;
            end else begin
                cnt_d   = cnt_q + 1'b1;
                state_d = (state_q == WAIT_ACK && !hostIsReady) ? WAIT_DONE : state_q;
            end
            DRAIN: state_d = hostIsReady ? IDLE : DRAIN;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            own_q       <= '0;
            grant_q     <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wr_q        <= 1'b0;
            cnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_to_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            own_q       <= own_d;
            grant_q     <= grant_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wr_q        <= wr_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_to_q    <= rsp_to_d;
        end
    end
    assign reqAccept   = state_q == ISSUE ? own_q : '0;
    assign hostStart   = state_q == ISSUE;
    assign rspValid    = rsp_valid_q;
    assign rspData     = rsp_data_q;
    assign rspTimeout  = rsp_to_q;
    assign hostAddr    = addr_q;
    assign hostInData  = wdata_q;
    assign hostIsWrite = wr_q;
    assign grantIdx    = grant_q;
    assign busy        = state_q != IDLE;
endmodule

// File: tb/tb_lpc_host_arbiter.sv
// tb_lpc_host_arbiter: directed checks of grant, read/write, arbitration order, timeout and async reset.
module tb_lpc_host_arbiter;
    logic        clk = 1'b0, reset = 1'b1;
    logic [1:0]  reqValid = '0, reqIsWrite = '0;
    logic [31:0] reqAddr = '0;
    logic [15:0] reqWData = '0;
    logic [1:0]  reqAccept, rspValid, grantIdx;
    logic [7:0]  rspData, hostInData;
    logic [7:0]  hostOutData = '0;
    logic        rspTimeout, hostIsWrite, hostStart, busy;
    logic [15:0] hostAddr;
    logic        hostIsReady = 1'b1, hostGotResponse = 1'b0;
    int          checks = 0, errors = 0, starts = 0;
    int          rem [2];
    int          who, k, s0, expw;
    logic [1:0]  rv, acc;
    logic [7:0]  rd;
    logic        rto;

    lpc_host_arbiter #(.NUM_REQ(2), .TIMEOUT_CYCLES(32)) dut (
        .clk(clk), .reset(reset), .reqValid(reqValid), .reqIsWrite(reqIsWrite),
        .reqAddr(reqAddr), .reqWData(reqWData), .reqAccept(reqAccept), .rspValid(rspValid),
        .rspData(rspData), .rspTimeout(rspTimeout), .hostAddr(hostAddr), .hostInData(hostInData),
        .hostIsWrite(hostIsWrite), .hostStart(hostStart), .hostIsReady(hostIsReady),
        .hostGotResponse(hostGotResponse), .hostOutData(hostOutData), .grantIdx(grantIdx), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (hostStart) starts <= starts + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Host model for one transaction: busy for lat cycles after hostStart, then completes.
    task automatic serve(input int lat, input logic [7:0] data, output int w, output logic [1:0] v,
                         output logic [7:0] d, output logic t);
        int n;
        n = 0;
        while (!hostStart && n < 20) begin
            tick();
            n++;
        end
        chk("start_seen", {30'd0, hostStart, |reqAccept}, 32'd3);
        w = reqAccept[1] ? 1 : 0;
        reqValid[w] = 1'b0;
        rem[w]--;
        hostIsReady = 1'b0;
        repeat (lat) tick();
        hostIsReady = 1'b1;
        if (!hostIsWrite) begin
            hostGotResponse = 1'b1;
            hostOutData = data;
        end
        tick();
        hostGotResponse = 1'b0;
        v = rspValid;
        d = rspData;
        t = rspTimeout;
        if (v[0] && rem[0] > 0) reqValid[0] = 1'b1;
        if (v[1] && rem[1] > 0) reqValid[1] = 1'b1;
        tick();
    endtask

    initial begin
        rem[0] = 0;
        rem[1] = 0;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_ctl", {reqAccept, rspValid, rspTimeout, hostStart, hostIsWrite, grantIdx}, 0);
        chk("rst_addr", hostAddr, 0);
        chk("rst_data", {rspData, hostInData}, 0);
        reset = 1'b0;
        tick();
        // read from requester 0
        reqValid = 2'b01;
        reqIsWrite = 2'b00;
        reqAddr = {16'h0024, 16'h0018};
        reqWData = {8'hA5, 8'h00};
        s0 = starts;
        tick();
        chk("t1_accept", reqAccept, 2'b01);
        chk("t1_start", hostStart, 1);
        chk("t1_addr", hostAddr, 16'h0018);
        chk("t1_iswr", hostIsWrite, 0);
        serve(20, 8'h81, who, rv, rd, rto);
        chk("t1_rsp", rv, 2'b01);
        chk("t1_data", rd, 8'h81);
        chk("t1_to", rto, 0);
        chk("t1_nstart", starts - s0, 1);
        chk("t1_idle", busy, 0);
        // write from requester 1
        reqValid = 2'b10;
        reqIsWrite = 2'b10;
        serve(5, 8'h00, who, rv, rd, rto);
        chk("t2_rsp", rv, 2'b10);
        chk("t2_to", rto, 0);
        chk("t2_wdata", hostInData, 8'hA5);
        chk("t2_iswr", hostIsWrite, 1);
        chk("t2_addr", hostAddr, 16'h0024);
        chk("t2_gidx", grantIdx, 1);
        // both requesters, three transactions each
        reqIsWrite = 2'b00;
        rem[0] = 3;
        rem[1] = 3;
        reqValid = 2'b11;
        for (int i = 0; i < 6; i++) begin
`ifdef LPC_ARB_ROUND_ROBIN_EN
            expw = i % 2;
`else
            expw = i < 3 ? 0 : 1;
`endif
            serve(3, 8'(i), who, rv, rd, rto);
            chk("t3_order", who, expw);
            chk("t3_rsp", rv, 32'd1 << expw);
        end
        chk("t3_done", {reqValid, busy}, 0);
        // hung host: timeout then drain
        reqValid = 2'b01;
        tick();
        chk("t4_start", hostStart, 1);
        reqValid = 2'b00;
        hostIsReady = 1'b0;
        k = 0;
        while (rspValid == 2'b00 && k < 40) begin
            tick();
            k++;
        end
        chk("t4_cycle", k, 32);
        chk("t4_rsp", rspValid, 2'b01);
        chk("t4_to", rspTimeout, 1);
        chk("t4_data", rspData, 8'hFF);
        chk("t4_busy", busy, 1);
        hostGotResponse = 1'b1;
        hostOutData = 8'h55;
        tick();
        hostGotResponse = 1'b0;
        chk("t4_drain_rsp", {rspValid, rspTimeout}, 0);
        repeat (3) tick();
        chk("t4_drain_busy", busy, 1);
        hostIsReady = 1'b1;
        reqValid = 2'b10;
        reqIsWrite = 2'b10;
        tick();
        chk("t4_idle", {busy, reqAccept}, 0);
        serve(4, 8'h00, who, rv, rd, rto);
        chk("t4_next_who", who, 1);
        chk("t4_next_rsp", {rv, rto}, 3'b100);
        // host not ready: no grant until it rises
        hostIsReady = 1'b0;
        reqValid = 2'b01;
        reqIsWrite = 2'b00;
        s0 = starts;
        acc = '0;
        repeat (5) begin
            tick();
            acc = acc | reqAccept;
        end
        chk("t5_noacc", {acc, busy}, 0);
        chk("t5_nostart", starts - s0, 0);
        hostIsReady = 1'b1;
        tick();
        chk("t5_start", {hostStart, reqAccept}, 3'b101);
        serve(3, 8'h3C, who, rv, rd, rto);
        chk("t5_rsp", {rv, rd}, {2'b01, 8'h3C});
        // async reset while waiting for read data
        reqValid = 2'b10;
        reqAddr = {16'h1234, 16'h0018};
        tick();
        reqValid = 2'b00;
        hostIsReady = 1'b0;
        repeat (4) tick();
        chk("t6_pre", {busy, grantIdx}, 3'b101);
        #2 reset = 1'b1;
        #1;
        chk("t6_async_ctl", {busy, grantIdx, reqAccept, rspValid, hostStart}, 0);
        chk("t6_async_dat", {hostAddr, rspData}, 0);
        tick();
        tick();
        reset = 1'b0;
        hostGotResponse = 1'b1;
        hostOutData = 8'h99;
        tick();
        hostGotResponse = 1'b0;
        hostIsReady = 1'b1;
        chk("t6_late", {rspValid, busy, rspData}, 0);
        tick();
        chk("t6_quiet", {rspValid, busy}, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired checks %0d errors %0d", checks, errors);
        $fatal(1);
    end
endmodule
